// File: rtl/aes_pkg.sv
// Shared AES-128 primitives: S-box, GF(2^8) doubling, round constants,
// state type and the iterative core's FSM encoding.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Entry 0x00 sits in the top byte so that the table reads like the usual 16x16 grid.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One AES-128 encryption round plus the matching key-schedule step.
// Purely combinational; no latency.
// No handshake; the enclosing core decides when results are registered.
module aes_round_unit
    import aes_pkg::*;
(
    input  aes_state_t  state_in,
    input  aes_state_t  key_in,
    input  logic [3:0]  round_idx,
    input  logic        is_final,
    output aes_state_t  state_out,
    output aes_state_t  key_out
);

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    aes_state_t  sub, shf, mix;
    logic [31:0] w0, w1, w2, w3, w0n, w1n, w2n, w3n, sub_rot;
    logic [7:0]  rcon;

    // Byte k of the state lives at [127-8k -: 8]; byte k is s[k%4, k/4].
    always_comb begin
        sub = '0;
        shf = '0;
        mix = '0;
        for (int k = 0; k < 16; k++) begin
            sub[127-8*k -: 8] = sbox(state_in[127-8*k -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf[127-8*(4*c+r) -: 8] = sub[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mix[127-32*c -: 32] = mix_column(shf[127-32*c -: 32]);
        end
    end

    assign {w0, w1, w2, w3} = key_in;
    assign rcon    = (round_idx >= 4'd1 && round_idx <= 4'd10) ? RCON[round_idx] : 8'h00;
    assign sub_rot = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign w0n     = w0 ^ sub_rot ^ {rcon, 24'h0};
    assign w1n     = w1 ^ w0n;
    assign w2n     = w2 ^ w1n;
    assign w3n     = w3 ^ w2n;
    assign key_out = {w0n, w1n, w2n, w3n};

    assign state_out = (is_final ? shf : mix) ^ key_out;

endmodule

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor, ROUNDS_PER_CYCLE rounds per clock, keys derived on the fly.
// Latency: 10/ROUNDS_PER_CYCLE cycles from accept edge to out_valid.
// Backpressure: holds the result while out_ready is low; in_ready only in IDLE.
module aes128_iter_core
    import aes_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
        ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_param
        $error("aes128_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    fsm_state_e state, state_nxt;
    aes_state_t st, st_nxt, rk, rk_nxt;
    logic [3:0] rnd, rnd_nxt;

    aes_state_t st_chain [0:ROUNDS_PER_CYCLE];
    aes_state_t rk_chain [0:ROUNDS_PER_CYCLE];

    assign st_chain[0] = st;
    assign rk_chain[0] = rk;

    // The final flag comes from the absolute round number, so MixColumns drops out at round 10 only.
    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
        logic [3:0] ridx;
        assign ridx = rnd + 4'(i + 1);

        aes_round_unit u_round (
            .state_in  (st_chain[i]),
            .key_in    (rk_chain[i]),
            .round_idx (ridx),
            .is_final  (ridx == 4'd10),
            .state_out (st_chain[i+1]),
            .key_out   (rk_chain[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            st    <= '0;
            rk    <= '0;
            rnd   <= '0;
        end else begin
            state <= state_nxt;
            st    <= st_nxt;
            rk    <= rk_nxt;
            rnd   <= rnd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        st_nxt    = st;
        rk_nxt    = rk;
        rnd_nxt   = rnd;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    st_nxt    = plaintext ^ key;
                    rk_nxt    = key;
                    rnd_nxt   = 4'd0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                st_nxt  = st_chain[ROUNDS_PER_CYCLE];
                rk_nxt  = rk_chain[ROUNDS_PER_CYCLE];
                rnd_nxt = rnd + 4'(ROUNDS_PER_CYCLE);
                if (rnd_nxt == 4'd10) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign ciphertext = st;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Scoreboard bench for aes128_iter_core at every legal ROUNDS_PER_CYCLE: FIPS-197
// vectors, back-pressure, reset mid-RUN, held in_valid, and random streaming against a reference model.
module tb_aes128_iter_core;

    localparam int NI = 4;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid   [NI];
    logic         in_ready   [NI];
    logic         out_valid  [NI];
    logic         out_ready  [NI];
    logic [127:0] ciphertext [NI];
    logic [127:0] plaintext, key;

    int           total = 0;
    int           bad   = 0;
    int           rx_cnt [NI] = '{default: 0};
    logic [127:0] exp_q  [NI][$];
    logic [7:0]   m_sbox [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int R = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
        aes128_iter_core #(.ROUNDS_PER_CYCLE(R)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .plaintext  (plaintext),
            .key        (key),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .ciphertext (ciphertext[g])
        );
    end

    function automatic int rpc_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {m_sbox[v[31:24]], m_sbox[v[23:16]], m_sbox[v[15:8]], m_sbox[v[7:0]]};
    endfunction

    function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int b = 0; b < 16; b++) t[b] = m_sbox[s[b]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = t[4*((c+row)%4)+row];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int b = 0; b < 16; b++) s[b] ^= w[4*r + b/4][31-8*(b%4) -: 8];
        end
        res = '0;
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send(input int k, input logic [127:0] pt, input logic [127:0] kk,
                        input bit push, input logic [127:0] exp);
        int w = 0;
        plaintext   = pt;
        key         = kk;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && w < 200) begin
            step();
            w++;
        end
        if (!in_ready[k]) begin
            total++;
            bad++;
            $display("FAIL accept_timeout inst%0d: got in_ready=0 want 1", k);
            in_valid[k] = 1'b0;
            return;
        end
        if (push) exp_q[k].push_back(exp);
        step();
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int exp_lat);
        int lat = 0;
        while (!out_valid[k] && lat < 40) begin
            step();
            lat++;
        end
        chk($sformatf("latency_r%0d", rpc_of(k)), 128'(lat), 128'(exp_lat));
    endtask

    task automatic stream(input int k, input int nblk);
        int start_rx = rx_cnt[k];
        fork
            begin
                logic [127:0] pt, kk;
                for (int i = 0; i < nblk; i++) begin
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    kk = {$urandom, $urandom, $urandom, $urandom};
                    repeat ($urandom_range(0, 3)) step();
                    send(k, pt, kk, 1'b1, aes_model(pt, kk));
                end
            end
            begin
                int guard = 0;
                while (rx_cnt[k] - start_rx < nblk && guard < 30000) begin
                    out_ready[k] = ($urandom_range(0, 3) != 0);
                    step();
                    guard++;
                end
            end
        join
        out_ready[k] = 1'b1;
        chk($sformatf("stream_count_r%0d", rpc_of(k)), 128'(rx_cnt[k] - start_rx), 128'(nblk));
        chk($sformatf("stream_leftover_r%0d", rpc_of(k)), 128'(exp_q[k].size()), 128'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) begin
                rx_cnt[k]++;
                if (exp_q[k].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out inst%0d: got %h want no output", k, ciphertext[k]);
                end else begin
                    chk($sformatf("ct_r%0d", rpc_of(k)), ciphertext[k], exp_q[k].pop_front());
                end
            end
        end
    end

    initial begin
        #700000;
        bad++;
        $display("FAIL watchdog: got still running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] inv;
        int seen;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
            end
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        rst_n     = 1'b0;
        plaintext = '0;
        key       = '0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
        end
        repeat (2) step();
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_in_ready_r%0d", rpc_of(k)), 128'(in_ready[k]), 128'd1);
            chk($sformatf("reset_out_valid_r%0d", rpc_of(k)), 128'(out_valid[k]), 128'd0);
            chk($sformatf("reset_ct_r%0d", rpc_of(k)), ciphertext[k], 128'd0);
        end
        rst_n = 1'b1;
        step();

        // FIPS-197 appendix B at one round per cycle
        send(0, PT_B, KEY_B, 1'b1, CT_B);
        wait_out(0, 10);
        step();
        chk("after_done_in_ready", 128'(in_ready[0]), 128'd1);
        chk("after_done_out_valid", 128'(out_valid[0]), 128'd0);

        // FIPS-197 C.1 on the unrolled variants
        for (int k = 1; k < NI; k++) begin
            send(k, PT_C, KEY_C, 1'b1, CT_C);
            wait_out(k, 10 / rpc_of(k));
            step();
        end

        // Back-pressure: result must hold and no new block may enter
        out_ready[0] = 1'b0;
        send(0, '0, '0, 1'b1, CT_Z);
        wait_out(0, 10);
        for (int i = 0; i < 7; i++) begin
            chk("bp_ct_hold", ciphertext[0], CT_Z);
            chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
            step();
        end
        out_ready[0] = 1'b1;
        chk("bp_in_ready_at_release", 128'(in_ready[0]), 128'd0);
        step();
        chk("bp_in_ready_after", 128'(in_ready[0]), 128'd1);
        chk("bp_out_valid_after", 128'(out_valid[0]), 128'd0);

        // in_valid held through RUN with a moving plaintext
        plaintext   = PT_C;
        key         = KEY_C;
        in_valid[0] = 1'b1;
        exp_q[0].push_back(CT_C);
        step();
        for (int i = 0; i < 40 && !out_valid[0]; i++) begin
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid[0] = 1'b0;
        chk("held_valid_done", 128'(out_valid[0]), 128'd1);
        step();
        step();
        chk("held_valid_idle", 128'(in_ready[0]), 128'd1);

        // Reset at E3 of a running block
        send(0, PT_B, KEY_B, 1'b0, '0);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrun_rst_in_ready", 128'(in_ready[0]), 128'd1);
        chk("midrun_rst_out_valid", 128'(out_valid[0]), 128'd0);
        chk("midrun_rst_ct", ciphertext[0], 128'd0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (15) begin
            if (out_valid[0]) seen++;
            step();
        end
        chk("midrun_no_stale_valid", 128'(seen), 128'd0);
        send(0, PT_B, KEY_B, 1'b1, CT_B);
        wait_out(0, 10);
        step();

        // Random streaming with gaps on both sides
        stream(0, 1000);
        for (int k = 1; k < NI; k++) stream(k, 200);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
